// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory arbiter: load/store opcode encodings,
//   the arbiter FSM state type, the transaction-kind type, one-hot grant
//   bit positions and the store-op decode helper.
//   No ports (package).
package mem_arbiter_pkg;

    // Load/store opcode encodings (INST_OP_WIDTH = 6)
    localparam logic [5:0] OP_LB  = 6'd12;
    localparam logic [5:0] OP_LH  = 6'd13;
    localparam logic [5:0] OP_LW  = 6'd14;
    localparam logic [5:0] OP_LBU = 6'd15;
    localparam logic [5:0] OP_LHU = 6'd16;
    localparam logic [5:0] OP_SB  = 6'd17;
    localparam logic [5:0] OP_SH  = 6'd18;
    localparam logic [5:0] OP_SW  = 6'd19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2
    } txn_kind_t;

    // Bit positions inside the one-hot winner vector
    localparam int G_FETCH = 0;
    localparam int G_LOAD  = 1;
    localparam int G_STORE = 2;

    // The op is widened to 32 bits by the caller so the decode works for any
    // op width up to 32.
    function automatic logic is_store_op(input logic [31:0] op);
        return (op == 32'(OP_SB)) || (op == 32'(OP_SH)) || (op == 32'(OP_SW));
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio
//   Combinational winner select for the memory arbiter.
//   Ports:
//     fet_pend  in   fetch request eligible this cycle
//     ld_pend   in   load request eligible this cycle
//     st_pend   in   store request eligible this cycle
//     starve    in   fetch has been passed over STARVE_LIMIT times
//     grant     out  one-hot winner {store, load, fetch}, zero if none
module mem_arb_prio
    import mem_arbiter_pkg::*;
(
    input  logic       fet_pend,
    input  logic       ld_pend,
    input  logic       st_pend,
    input  logic       starve,
    output logic [2:0] grant
);

    always_comb begin
        grant = '0;
        // A starved fetch jumps ahead of everything else.
        if (starve && fet_pend) begin
            grant[G_FETCH] = 1'b1;
        end else if (st_pend) begin
            grant[G_STORE] = 1'b1;
        end else if (ld_pend) begin
            grant[G_LOAD] = 1'b1;
        end else if (fet_pend) begin
            grant[G_FETCH] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates the memory controller's single RAM port between the
//   instruction fetcher and the load/store buffer. One enable pulse is issued
//   per transaction, which is then tracked to completion. Flushes abandon
//   in-flight fetches/loads (draining the controller), stores always finish.
//   Ports:
//     clk, rst (sync, active-low), rdy (global enable), flush
//     fet_req/fet_pc -> fet_grant                 fetch request side
//     lsb_req/op/addr/data/id -> lsb_grant        LSB request side
//     arb_fet_enable, arb_fet_pc                  fetch issue to controller
//     arb_lsb_enable/op/addr/data/id              LSB issue to controller
//     mem_fet_busy, mem_inst_ready, mem_data_ready controller status
//     arb_busy                                    arbiter not idle
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ROB_SIZE_WIDTH = 4,
    parameter int INST_OP_WIDTH  = 6,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      fet_req,
    input  logic [XLEN-1:0]           fet_pc,
    output logic                      fet_grant,
    input  logic                      lsb_req,
    input  logic [INST_OP_WIDTH-1:0]  lsb_op,
    input  logic [XLEN-1:0]           lsb_addr,
    input  logic [XLEN-1:0]           lsb_data,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_id,
    output logic                      lsb_grant,
    output logic                      arb_fet_enable,
    output logic [XLEN-1:0]           arb_fet_pc,
    output logic                      arb_lsb_enable,
    output logic [INST_OP_WIDTH-1:0]  arb_lsb_op,
    output logic [XLEN-1:0]           arb_lsb_addr,
    output logic [XLEN-1:0]           arb_lsb_data,
    output logic [ROB_SIZE_WIDTH-1:0] arb_lsb_id,
    input  logic                      mem_fet_busy,
    input  logic                      mem_inst_ready,
    input  logic                      mem_data_ready,
    output logic                      arb_busy
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    txn_kind_t         kind;
    logic [SC_W-1:0]   starve_cnt;

    logic [XLEN-1:0]           fet_pc_q;
    logic [INST_OP_WIDTH-1:0]  lsb_op_q;
    logic [XLEN-1:0]           lsb_addr_q;
    logic [XLEN-1:0]           lsb_data_q;
    logic [ROB_SIZE_WIDTH-1:0] lsb_id_q;

    logic       sel_ok;
    logic       lsb_is_store;
    logic       fet_pend;
    logic       ld_pend;
    logic       st_pend;
    logic       starve;
    logic [2:0] win;
    logic       any_win;

    // Selection only happens from IDLE with the controller idle. Flush masks
    // fetch and load candidates, but a store is committed work and stays
    // eligible.
    assign sel_ok       = (state == ST_IDLE) && !mem_fet_busy;
    assign lsb_is_store = is_store_op(32'(lsb_op));
    assign fet_pend     = sel_ok && fet_req && !flush;
    assign st_pend      = sel_ok && lsb_req && lsb_is_store;
    assign ld_pend      = sel_ok && lsb_req && !lsb_is_store && !flush;
    assign starve       = (starve_cnt == SC_W'(STARVE_LIMIT));
    assign any_win      = |win;

    mem_arb_prio u_prio (
        .fet_pend (fet_pend),
        .ld_pend  (ld_pend),
        .st_pend  (st_pend),
        .starve   (starve),
        .grant    (win)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any_win) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (flush && kind != KIND_STORE) state_nxt = ST_DRAIN;
                else                             state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Flush beats a same-cycle ready pulse for fetch/load.
                if (flush && kind != KIND_STORE) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    case (kind)
                        KIND_FETCH: if (mem_inst_ready) state_nxt = ST_IDLE;
                        KIND_LOAD:  if (mem_data_ready) state_nxt = ST_IDLE;
                        default:    if (!mem_fet_busy)  state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_DRAIN: begin
                if (!mem_fet_busy) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: enables and grants are the same single ISSUE-cycle pulse.
    always_comb begin
        arb_fet_enable = (state == ST_ISSUE) && (kind == KIND_FETCH);
        arb_lsb_enable = (state == ST_ISSUE) && (kind != KIND_FETCH);
        fet_grant      = arb_fet_enable;
        lsb_grant      = arb_lsb_enable;
        arb_busy       = (state != ST_IDLE);
        arb_fet_pc     = fet_pc_q;
        arb_lsb_op     = lsb_op_q;
        arb_lsb_addr   = lsb_addr_q;
        arb_lsb_data   = lsb_data_q;
        arb_lsb_id     = lsb_id_q;
    end

    // Transaction kind and operand capture at the moment of selection.
    // Operands are cleared on reset so every output reads zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            kind       <= KIND_FETCH;
            fet_pc_q   <= '0;
            lsb_op_q   <= '0;
            lsb_addr_q <= '0;
            lsb_data_q <= '0;
            lsb_id_q   <= '0;
        end else if (rdy && any_win) begin
            if (win[G_FETCH]) begin
                kind     <= KIND_FETCH;
                fet_pc_q <= fet_pc;
            end else begin
                kind       <= win[G_STORE] ? KIND_STORE : KIND_LOAD;
                lsb_op_q   <= lsb_op;
                lsb_addr_q <= lsb_addr;
                lsb_data_q <= lsb_data;
                lsb_id_q   <= lsb_id;
            end
        end
    end

    // Fetch starvation counter: counts LSB grants that happen while a fetch
    // is waiting; a fetch grant clears it. Flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (rdy && state == ST_ISSUE) begin
            if (kind == KIND_FETCH) begin
                starve_cnt <= '0;
            end else if (fet_req && !starve) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Scoreboard bench for mem_arbiter: every request the bench drives pushes
//   the transaction it expects to see issued; a negedge monitor pops and
//   compares whenever an enable is observed.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        fet_req;
    logic [31:0] fet_pc;
    logic        fet_grant;
    logic        lsb_req;
    logic [5:0]  lsb_op;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_data;
    logic [3:0]  lsb_id;
    logic        lsb_grant;
    logic        arb_fet_enable;
    logic [31:0] arb_fet_pc;
    logic        arb_lsb_enable;
    logic [5:0]  arb_lsb_op;
    logic [31:0] arb_lsb_addr;
    logic [31:0] arb_lsb_data;
    logic [3:0]  arb_lsb_id;
    logic        mem_fet_busy;
    logic        mem_inst_ready;
    logic        mem_data_ready;
    logic        arb_busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit          is_lsb;
        logic [31:0] addr;
        logic [31:0] data;
        logic [5:0]  op;
        logic [3:0]  id;
    } exp_t;

    exp_t sb_q[$];

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .flush          (flush),
        .fet_req        (fet_req),
        .fet_pc         (fet_pc),
        .fet_grant      (fet_grant),
        .lsb_req        (lsb_req),
        .lsb_op         (lsb_op),
        .lsb_addr       (lsb_addr),
        .lsb_data       (lsb_data),
        .lsb_id         (lsb_id),
        .lsb_grant      (lsb_grant),
        .arb_fet_enable (arb_fet_enable),
        .arb_fet_pc     (arb_fet_pc),
        .arb_lsb_enable (arb_lsb_enable),
        .arb_lsb_op     (arb_lsb_op),
        .arb_lsb_addr   (arb_lsb_addr),
        .arb_lsb_data   (arb_lsb_data),
        .arb_lsb_id     (arb_lsb_id),
        .mem_fet_busy   (mem_fet_busy),
        .mem_inst_ready (mem_inst_ready),
        .mem_data_ready (mem_data_ready),
        .arb_busy       (arb_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fet(input logic [31:0] pc);
        exp_t e;
        e.is_lsb = 1'b0; e.addr = pc; e.data = '0; e.op = '0; e.id = '0;
        sb_q.push_back(e);
    endtask

    task automatic push_lsb(input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] id);
        exp_t e;
        e.is_lsb = 1'b1; e.addr = addr; e.data = data; e.op = op; e.id = id;
        sb_q.push_back(e);
    endtask

    // Tick until the requested grant is seen, bounded.
    task automatic wait_grant(input bit lsb, input string tag);
        int n = 0;
        while (!(lsb ? lsb_grant : fet_grant) && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 64'(lsb ? lsb_grant : fet_grant), 64'd1);
    endtask

    // Called in the ISSUE cycle; plays the controller through completion.
    // kind: 0 fetch, 1 load, 2 store. Leaves the arbiter in IDLE.
    task automatic complete(input int kind);
        mem_fet_busy = 1'b1;
        tick();
        mem_fet_busy = 1'b0;
        if (kind == 0) mem_inst_ready = 1'b1;
        if (kind == 1) mem_data_ready = 1'b1;
        tick();
        mem_inst_ready = 1'b0;
        mem_data_ready = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst && rdy && (arb_fet_enable || arb_lsb_enable)) begin
            chk("both_enables", 64'(arb_fet_enable & arb_lsb_enable), 64'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_issue", 64'({arb_fet_enable, arb_lsb_enable}), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("issue_is_lsb", 64'(arb_lsb_enable), 64'(e.is_lsb));
                if (e.is_lsb) begin
                    chk("issue_op",   64'(arb_lsb_op),   64'(e.op));
                    chk("issue_addr", 64'(arb_lsb_addr), 64'(e.addr));
                    chk("issue_data", 64'(arb_lsb_data), 64'(e.data));
                    chk("issue_id",   64'(arb_lsb_id),   64'(e.id));
                end else begin
                    chk("issue_pc",   64'(arb_fet_pc),   64'(e.addr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        fet_req = 1'b0; fet_pc = '0;
        lsb_req = 1'b0; lsb_op = '0; lsb_addr = '0; lsb_data = '0; lsb_id = '0;
        mem_fet_busy = 1'b0; mem_inst_ready = 1'b0; mem_data_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_busy",     64'(arb_busy), 64'd0);
        chk("rst_fet_en",   64'(arb_fet_enable), 64'd0);
        chk("rst_lsb_en",   64'(arb_lsb_enable), 64'd0);
        chk("rst_starve",   64'(dut.starve_cnt), 64'd0);
        rst = 1'b1;
        tick();

        // 1: single fetch, exact issue timing
        fet_req = 1'b1; fet_pc = 32'h1000;
        push_fet(32'h1000);
        tick();
        chk("t1_fet_grant", 64'(fet_grant), 64'd1);
        chk("t1_fet_en",    64'(arb_fet_enable), 64'd1);
        chk("t1_busy",      64'(arb_busy), 64'd1);
        fet_req = 1'b0;
        mem_fet_busy = 1'b1;
        tick();
        chk("t1_grant_drop", 64'(fet_grant), 64'd0);
        chk("t1_en_drop",    64'(arb_fet_enable), 64'd0);
        chk("t1_wait",       64'(dut.state), 64'(ST_WAIT));
        tick();
        mem_fet_busy = 1'b0; mem_inst_ready = 1'b1;
        tick();
        mem_inst_ready = 1'b0;
        chk("t1_idle", 64'(arb_busy), 64'd0);

        // 2: simultaneous fetch + store, store first
        fet_req = 1'b1; fet_pc = 32'h2000;
        lsb_req = 1'b1; lsb_op = OP_SW; lsb_addr = 32'h20000; lsb_data = 32'hDEADBEEF; lsb_id = 4'd3;
        push_lsb(OP_SW, 32'h20000, 32'hDEADBEEF, 4'd3);
        push_fet(32'h2000);
        tick();
        chk("t2_store_grant", 64'(lsb_grant), 64'd1);
        chk("t2_no_fet",      64'(fet_grant), 64'd0);
        lsb_req = 1'b0;
        mem_fet_busy = 1'b1;
        tick(); tick(); tick();
        chk("t2_fetch_held",  64'(arb_fet_enable), 64'd0);
        chk("t2_store_wait",  64'(dut.state), 64'(ST_WAIT));
        mem_fet_busy = 1'b0;
        wait_grant(1'b0, "t2_fetch_after_store");
        fet_req = 1'b0;
        complete(0);
        chk("t2_idle", 64'(arb_busy), 64'd0);

        // 3: fetch starvation limit
        fet_req = 1'b1; fet_pc = 32'h3000;
        lsb_req = 1'b1; lsb_op = OP_LW;
        for (int i = 0; i < 4; i++) begin
            lsb_addr = 32'h100 + 32'(4 * i); lsb_data = 32'(i); lsb_id = 4'(i);
            push_lsb(OP_LW, 32'h100 + 32'(4 * i), 32'(i), 4'(i));
            wait_grant(1'b1, "t3_load_grant");
            complete(1);
        end
        chk("t3_starve_full", 64'(dut.starve_cnt), 64'd4);
        lsb_addr = 32'h200; lsb_data = 32'h55; lsb_id = 4'd9;
        push_fet(32'h3000);
        push_lsb(OP_LW, 32'h200, 32'h55, 4'd9);
        wait_grant(1'b0, "t3_fetch_wins");
        chk("t3_no_lsb", 64'(lsb_grant), 64'd0);
        fet_req = 1'b0;
        mem_fet_busy = 1'b1;
        tick();
        chk("t3_starve_clear", 64'(dut.starve_cnt), 64'd0);
        mem_fet_busy = 1'b0; mem_inst_ready = 1'b1;
        tick();
        mem_inst_ready = 1'b0;
        wait_grant(1'b1, "t3_load5");
        lsb_req = 1'b0;
        complete(1);

        // 4: flush during load WAIT -> DRAIN
        lsb_req = 1'b1; lsb_op = OP_LW; lsb_addr = 32'h44; lsb_data = 32'h0; lsb_id = 4'd5;
        push_lsb(OP_LW, 32'h44, 32'h0, 4'd5);
        wait_grant(1'b1, "t4_load_grant");
        lsb_req = 1'b0;
        mem_fet_busy = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_drain", 64'(dut.state), 64'(ST_DRAIN));
        fet_req = 1'b1; fet_pc = 32'h4000;
        push_fet(32'h4000);
        mem_data_ready = 1'b1;
        tick();
        mem_data_ready = 1'b0;
        chk("t4_ready_ignored", 64'(dut.state), 64'(ST_DRAIN));
        tick();
        chk("t4_no_issue", 64'({arb_fet_enable, arb_lsb_enable}), 64'd0);
        mem_fet_busy = 1'b0;
        tick();
        chk("t4_idle", 64'(arb_busy), 64'd0);
        wait_grant(1'b0, "t4_fetch_after_drain");
        fet_req = 1'b0;
        complete(0);

        // 5: store ignores flush; flush lets store but not load through IDLE
        lsb_req = 1'b1; lsb_op = OP_SW; lsb_addr = 32'h50; lsb_data = 32'h12345678; lsb_id = 4'd6;
        push_lsb(OP_SW, 32'h50, 32'h12345678, 4'd6);
        wait_grant(1'b1, "t5_store_grant");
        lsb_req = 1'b0;
        mem_fet_busy = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_no_drain", 64'(dut.state), 64'(ST_WAIT));
        mem_fet_busy = 1'b0;
        tick();
        chk("t5_store_done", 64'(arb_busy), 64'd0);
        lsb_req = 1'b1; lsb_op = OP_SB; lsb_addr = 32'h51; lsb_data = 32'hAB; lsb_id = 4'd7;
        flush = 1'b1;
        push_lsb(OP_SB, 32'h51, 32'hAB, 4'd7);
        tick();
        flush = 1'b0;
        chk("t5_sb_under_flush", 64'(lsb_grant), 64'd1);
        lsb_req = 1'b0;
        complete(2);
        lsb_req = 1'b1; lsb_op = OP_LH; lsb_addr = 32'h52; lsb_data = 32'h0; lsb_id = 4'd8;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_load_blocked", 64'(lsb_grant), 64'd0);
        push_lsb(OP_LH, 32'h52, 32'h0, 4'd8);
        wait_grant(1'b1, "t5_load_after_flush");
        lsb_req = 1'b0;
        complete(1);

        // 6: rdy stall mid-WAIT, then reset mid-transaction
        lsb_req = 1'b1; lsb_op = OP_LW; lsb_addr = 32'h60; lsb_data = 32'h77; lsb_id = 4'd10;
        push_lsb(OP_LW, 32'h60, 32'h77, 4'd10);
        wait_grant(1'b1, "t6_load_grant");
        lsb_req = 1'b0;
        mem_fet_busy = 1'b1;
        tick();
        rdy = 1'b0;
        mem_data_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_hold_state", 64'(dut.state), 64'(ST_WAIT));
            chk("t6_hold_addr",  64'(arb_lsb_addr), 64'h60);
        end
        mem_data_ready = 1'b0;
        rdy = 1'b1;
        tick();
        chk("t6_still_wait", 64'(dut.state), 64'(ST_WAIT));
        rst = 1'b0;
        tick();
        chk("t6_rst_busy", 64'(arb_busy), 64'd0);
        chk("t6_rst_en",   64'({arb_fet_enable, arb_lsb_enable}), 64'd0);
        chk("t6_rst_addr", 64'(arb_lsb_addr), 64'd0);
        chk("t6_rst_data", 64'(arb_lsb_data), 64'd0);
        chk("t6_rst_id",   64'(arb_lsb_id), 64'd0);
        chk("t6_rst_pc",   64'(arb_fet_pc), 64'd0);
        mem_fet_busy = 1'b0;
        rst = 1'b1;
        tick();

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
